// File: rtl/uart_rx.sv
// UART receiver: 8N1 framing with 3-sample majority voting at mid-bit,
// ready/acknowledge handshake, frame error and overrun reporting.
module uart_rx #(
    parameter int DIV = 16,
    parameter int OVS = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    input  logic       rd,
    output logic [7:0] data,
    output logic       rdy,
    output logic       valid,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int BIT  = DIV * OVS;
    localparam int HALF = BIT / 2;
    localparam int CW   = $clog2(BIT + 2);

    // Sample points: in START the centre is measured from the detected edge,
    // afterwards from one clock past the previous decision.
    localparam logic [CW-1:0] START_S0  = CW'(HALF - 1);
    localparam logic [CW-1:0] START_S1  = CW'(HALF);
    localparam logic [CW-1:0] START_DEC = CW'(HALF + 1);
    localparam logic [CW-1:0] BIT_S0    = CW'(BIT - 2);
    localparam logic [CW-1:0] BIT_S1    = CW'(BIT - 1);
    localparam logic [CW-1:0] BIT_DEC   = CW'(BIT);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t          state_q, state_d;
    logic            sync1_q;
    logic            rx_s_q;
    logic            rx_prev_q;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [1:0]      samp_q, samp_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      data_q, data_d;
    logic            new_byte_q, new_byte_d;
    logic            valid_q, valid_d;
    logic            rdy_q, rdy_d;
    logic            frame_err_q, frame_err_d;
    logic            overrun_q, overrun_d;

    logic [CW-1:0]   s0_pt;
    logic [CW-1:0]   s1_pt;
    logic [CW-1:0]   dec_pt;
    logic            maj;

    always_comb begin
        s0_pt  = BIT_S0;
        s1_pt  = BIT_S1;
        dec_pt = BIT_DEC;
        if (state_q == START) begin
            s0_pt  = START_S0;
            s1_pt  = START_S1;
            dec_pt = START_DEC;
        end
    end

    assign maj = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s_q) | (samp_q[1] & rx_s_q);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        samp_d      = samp_q;
        shift_d     = shift_q;
        data_d      = data_q;
        new_byte_d  = 1'b0;
        frame_err_d = 1'b0;
        valid_d     = new_byte_q;

        case (state_q)
            IDLE: begin
                cnt_d     = '0;
                bit_idx_d = '0;
                if (rx_prev_q && !rx_s_q) begin
                    state_d = START;
                end
            end
            START, DATA, STOP: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == s0_pt) begin
                    samp_d[0] = rx_s_q;
                end
                if (cnt_q == s1_pt) begin
                    samp_d[1] = rx_s_q;
                end
                if (cnt_q == dec_pt) begin
                    // Decision is one clock past the centre, so restart at 1
                    // to keep the next centre exactly one bit period later.
                    cnt_d = CW'(1);
                    case (state_q)
                        START: begin
                            if (maj) begin
                                state_d = IDLE;
                            end else begin
                                state_d   = DATA;
                                bit_idx_d = '0;
                            end
                        end
                        DATA: begin
                            shift_d[bit_idx_q] = maj;
                            if (bit_idx_q == 3'd7) begin
                                state_d = STOP;
                            end else begin
                                bit_idx_d = bit_idx_q + 3'd1;
                            end
                        end
                        default: begin
                            state_d = IDLE;
                            if (maj) begin
                                data_d     = shift_q;
                                new_byte_d = 1'b1;
                            end else begin
                                frame_err_d = 1'b1;
                            end
                        end
                    endcase
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Handshake: a new byte always wins over a same-cycle acknowledge.
    always_comb begin
        rdy_d     = rdy_q;
        overrun_d = 1'b0;
        if (new_byte_q) begin
            rdy_d     = 1'b1;
            overrun_d = rdy_q && !rd;
        end else if (rd) begin
            rdy_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sync1_q     <= 1'b1;
            rx_s_q      <= 1'b1;
            rx_prev_q   <= 1'b1;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            samp_q      <= 2'b11;
            shift_q     <= 8'h00;
            data_q      <= 8'h00;
            new_byte_q  <= 1'b0;
            valid_q     <= 1'b0;
            rdy_q       <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= rx;
            rx_s_q      <= sync1_q;
            rx_prev_q   <= rx_s_q;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            samp_q      <= samp_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            new_byte_q  <= new_byte_d;
            valid_q     <= valid_d;
            rdy_q       <= rdy_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign data      = data_q;
    assign rdy       = rdy_q;
    assign valid     = valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus random frames,
// checked every cycle against a frame-level expectation queue.
module tb_uart_rx;

    localparam int DIV  = 16;
    localparam int OVS  = 16;
    localparam int BIT  = DIV * OVS;
    // Clocks from the first clock that samples the start edge (counted as 1)
    // to the clock at which valid is seen high.
    localparam int VLAT = 2438;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       rd = 1'b0;
    logic [7:0] data;
    logic       rdy, valid, frame_err, overrun, busy;

    uart_rx #(.DIV(DIV), .OVS(OVS)) dut (
        .clk(clk), .rst_n(rst_n), .rx(rx), .rd(rd),
        .data(data), .rdy(rdy), .valid(valid),
        .frame_err(frame_err), .overrun(overrun), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] b;
        logic       err;
        int         e0;
    } exp_t;

    exp_t       exp_q[$];
    int         n_checks = 0;
    int         n_fail = 0;
    int         n_valid = 0;
    int         n_ferr = 0;
    int         n_ovr = 0;
    int         last_lat = -1;
    logic       model_rdy = 1'b0;
    logic [7:0] model_data = 8'h00;
    logic       rd_last = 1'b0;
    int         rd_mode = 0;

    task automatic chk(input string name, input bit ok, input longint act, input longint req);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // All drive tasks start and end at posedge+1.
    task automatic hold(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_ok, input int brk, input int gap);
        exp_t e;
        rx   = 1'b0;
        e.b  = b;
        e.err = !stop_ok;
        e.e0 = cyc + 1;
        exp_q.push_back(e);
        hold(BIT);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            hold(BIT);
        end
        rx = stop_ok;
        hold(BIT);
        if (!stop_ok) hold(brk);
        rx = 1'b1;
        hold(gap);
    endtask

    // rd driver: 0 idle, 1 random, 2 acknowledge each valid, 3 held high
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rd_mode)
                1:       rd = ($urandom_range(0, 7) == 0);
                2:       rd = valid;
                3:       rd = 1'b1;
                default: rd = 1'b0;
            endcase
        end
    end

    // Compare process: frame-level model of what each cycle must show.
    initial begin
        int  lat;
        bit  ovr_exp;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                model_rdy  = 1'b0;
                model_data = 8'h00;
                rd_last    = rd;
                continue;
            end
            ovr_exp = 1'b0;
            if (exp_q.size() > 0 && (cyc - exp_q[0].e0 + 1) > VLAT + 1) begin
                chk("event_timeout", 1'b0, cyc - exp_q[0].e0 + 1, VLAT);
                exp_q.delete(0);
            end
            lat = (exp_q.size() > 0) ? (cyc - exp_q[0].e0 + 1) : 0;
            if (valid) begin
                n_valid++;
                if (exp_q.size() > 0 && !exp_q[0].err && lat >= VLAT - 1) begin
                    chk("valid_data", data == exp_q[0].b, data, exp_q[0].b);
                    last_lat   = lat;
                    model_data = exp_q[0].b;
                    exp_q.delete(0);
                end else begin
                    chk("unexpected_valid", 1'b0, 1, 0);
                end
                ovr_exp   = model_rdy && !rd_last;
                model_rdy = 1'b1;
            end else if (rd_last) begin
                model_rdy = 1'b0;
            end
            if (frame_err) begin
                n_ferr++;
                if (exp_q.size() > 0 && exp_q[0].err && lat >= VLAT - 3) begin
                    chk("ferr_data_kept", data == model_data, data, model_data);
                    exp_q.delete(0);
                end else begin
                    chk("unexpected_frame_err", 1'b0, 1, 0);
                end
            end else if (!valid && (exp_q.size() == 0 || lat < VLAT - 3)) begin
                chk("data_hold", data == model_data, data, model_data);
            end
            chk("rdy", rdy == model_rdy, rdy, model_rdy);
            chk("overrun", overrun == ovr_exp, overrun, ovr_exp);
            if (overrun) n_ovr++;
            rd_last = rd;
        end
    end

    initial begin
        int v0, f0, o0, e0g, t_low;
        bit seen_busy;
        logic [7:0] rb;
        logic       rok;

        // Reset values
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("rst_data", data == 8'h00, data, 0);
        chk("rst_rdy", rdy == 1'b0, rdy, 0);
        chk("rst_valid", valid == 1'b0, valid, 0);
        chk("rst_ferr", frame_err == 1'b0, frame_err, 0);
        chk("rst_ovr", overrun == 1'b0, overrun, 0);
        chk("rst_busy", busy == 1'b0, busy, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        hold(20);

        // Single byte 0xA5 with latency
        send_frame(8'hA5, 1'b1, 0, BIT);
        chk("a5_count", n_valid == 1, n_valid, 1);
        chk("a5_data", data == 8'hA5, data, 8'hA5);
        chk("a5_rdy", rdy == 1'b1, rdy, 1);
        chk("a5_latency", last_lat >= 2437 && last_lat <= 2439, last_lat, 2438);

        // Acknowledge, then back-to-back 0x00, 0xFF with rd after each valid
        rd_mode = 3;
        hold(2);
        rd_mode = 0;
        hold(2);
        chk("ack_clears_rdy", rdy == 1'b0, rdy, 0);
        v0 = n_valid;
        o0 = n_ovr;
        rd_mode = 2;
        send_frame(8'h00, 1'b1, 0, 0);
        send_frame(8'hFF, 1'b1, 0, BIT);
        rd_mode = 0;
        hold(2);
        chk("b2b_rd_count", n_valid == v0 + 2, n_valid - v0, 2);
        chk("b2b_rd_data", data == 8'hFF, data, 8'hFF);
        chk("b2b_rd_no_ovr", n_ovr == o0, n_ovr - o0, 0);

        // Same frames without acknowledge: second one overruns
        v0 = n_valid;
        send_frame(8'h00, 1'b1, 0, 0);
        send_frame(8'hFF, 1'b1, 0, BIT);
        chk("b2b_nord_count", n_valid == v0 + 2, n_valid - v0, 2);
        chk("b2b_nord_ovr", n_ovr == o0 + 1, n_ovr - o0, 1);
        chk("b2b_nord_data", data == 8'hFF, data, 8'hFF);
        chk("b2b_nord_rdy", rdy == 1'b1, rdy, 1);

        // 100-clock low glitch: false start, no pulses
        v0 = n_valid;
        f0 = n_ferr;
        rx = 1'b0;
        e0g = cyc + 1;
        hold(100);
        rx = 1'b1;
        seen_busy = 1'b0;
        t_low = -1;
        for (int i = 0; i < 200 && t_low < 0; i++) begin
            @(negedge clk);
            if (busy) seen_busy = 1'b1;
            else if (seen_busy) t_low = cyc - e0g + 1;
        end
        hold(BIT);
        chk("glitch_busy_seen", seen_busy, seen_busy, 1);
        chk("glitch_busy_low", t_low > 0 && t_low <= 134, t_low, 133);
        chk("glitch_no_valid", n_valid == v0, n_valid - v0, 0);
        chk("glitch_no_ferr", n_ferr == f0, n_ferr - f0, 0);

        // Bad stop bit followed by a break, then a good frame
        send_frame(8'h3C, 1'b0, 2 * BIT, BIT);
        chk("ferr_count", n_ferr == f0 + 1, n_ferr - f0, 1);
        chk("ferr_data", data == 8'hFF, data, 8'hFF);
        chk("ferr_rdy", rdy == 1'b1, rdy, 1);
        send_frame(8'h11, 1'b1, 0, BIT);
        chk("after_ferr_data", data == 8'h11, data, 8'h11);

        // Reset in the middle of data bit 4
        v0 = n_valid;
        rb = 8'hC3;
        rx = 1'b0;
        hold(BIT);
        for (int i = 0; i < 4; i++) begin
            rx = rb[i];
            hold(BIT);
        end
        rx = rb[4];
        hold(BIT / 2);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_data", data == 8'h00, data, 0);
        chk("midrst_rdy", rdy == 1'b0, rdy, 0);
        chk("midrst_busy", busy == 1'b0, busy, 0);
        chk("midrst_pulses", {valid, frame_err, overrun} == 3'b000, {valid, frame_err, overrun}, 0);
        hold(2);
        rx = 1'b1;
        rst_n = 1'b1;
        hold(BIT);
        chk("midrst_no_valid", n_valid == v0, n_valid - v0, 0);
        send_frame(8'h5A, 1'b1, 0, BIT);
        chk("midrst_next_data", data == 8'h5A, data, 8'h5A);

        // Random frames with random acknowledge
        rd_mode = 1;
        for (int k = 0; k < 10; k++) begin
            rb  = 8'($urandom_range(0, 255));
            rok = ($urandom_range(0, 5) != 0);
            if (rok) send_frame(rb, 1'b1, 0, $urandom_range(0, BIT / 2));
            else     send_frame(rb, 1'b0, $urandom_range(0, BIT), BIT);
        end
        rd_mode = 0;
        hold(2 * BIT);
        chk("all_events_seen", exp_q.size() == 0, exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
